// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device clock falling edges, then samples the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam logic [13:0] INH_LAST = 14'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] sat_inc_idx(input logic [3:0] idx);
    return (idx == 4'd10) ? 4'd10 : idx + 4'd1;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  data_sync_q, data_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [13:0] inh_cnt_q, inh_cnt_d;
  logic [20:0] to_cnt_q, to_cnt_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        ack_pend_q, ack_pend_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        timeout_err_q, timeout_err_d;

  logic clk_s, data_s, fe, to_hit;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = clk_prev_q & ~clk_s;
  assign to_hit = (to_cnt_q == TO_LAST);

  assign tx_ready    = (state_q == S_IDLE) && !done_q;
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    clk_sync_d    = {clk_sync_q[0], ps2_clk_i};
    data_sync_d   = {data_sync_q[0], ps2_data_i};
    clk_prev_d    = clk_s;
    state_d       = state_q;
    frame_d       = frame_q;
    bit_idx_d     = bit_idx_q;
    inh_cnt_d     = inh_cnt_q;
    to_cnt_d      = to_cnt_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    ack_pend_d    = ack_pend_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    // Timed states: any falling edge restarts the no-activity window.
    if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      to_cnt_d = fe ? '0 : to_cnt_q + 21'd1;
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 14'd1;
        end
      end
      S_START: begin
        clk_oe_d  = 1'b0;
        bit_idx_d = '0;
        to_cnt_d  = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fe) begin
          data_oe_d = ~frame_q[bit_idx_q];
          bit_idx_d = sat_inc_idx(bit_idx_q);
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          ack_pend_d = data_s;
          state_d    = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_s && data_s) begin
          done_d    = 1'b1;
          ack_err_d = ack_pend_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins only when the window expired with no edge and no normal exit this cycle.
    if ((state_q == S_SHIFT || state_q == S_ACK || state_q == S_WAIT_IDLE) &&
        !fe && to_hit && !(state_q == S_WAIT_IDLE && clk_s && data_s)) begin
      clk_oe_d      = 1'b0;
      data_oe_d     = 1'b0;
      done_d        = 1'b1;
      ack_err_d     = 1'b0;
      timeout_err_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      clk_prev_q    <= 1'b1;
      frame_q       <= '0;
      bit_idx_q     <= '0;
      inh_cnt_q     <= '0;
      to_cnt_q      <= '0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      ack_pend_q    <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      frame_q       <= frame_d;
      bit_idx_q     <= bit_idx_d;
      inh_cnt_q     <= inh_cnt_d;
      to_cnt_q      <= to_cnt_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      ack_pend_q    <= ack_pend_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
